// File: rtl/l1_pkg.sv
// Shared state encodings, memory command codes and geometry helpers for the L1 miss controller.
package l1_pkg;

  localparam logic [2:0] S_RST_WAIT = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_WB_RD    = 3'd2;
  localparam logic [2:0] S_WB_REQ   = 3'd3;
  localparam logic [2:0] S_RD_REQ   = 3'd4;
  localparam logic [2:0] S_FILL     = 3'd5;
  localparam logic [2:0] S_REPLAY   = 3'd6;

  localparam logic MEM_CMD_RD = 1'b0;
  localparam logic MEM_CMD_WR = 1'b1;

  function automatic int calc_off_w(input int beat_num, input int beat_width);
    return $clog2(beat_num * beat_width / 8);
  endfunction

  function automatic int calc_tag_w(input int addr_width, input int idx_width, input int off_w);
    return addr_width - idx_width - off_w;
  endfunction

endpackage

// File: rtl/l1_miss_ctrl.sv
// L1 miss sequencer: optional dirty write-back, line refill, tag write, then a one-cycle replay.
// One miss in flight; memory requests hold until acked, refill beats are taken whenever they arrive.
module l1_miss_ctrl
  import l1_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 7,
  parameter int WAY_NUM    = 4,
  parameter int BEAT_WIDTH = 32,
  parameter int BEAT_NUM   = 4,
  localparam int OFF_W     = calc_off_w(BEAT_NUM, BEAT_WIDTH),
  localparam int TAG_W     = calc_tag_w(ADDR_WIDTH, IDX_WIDTH, OFF_W),
  localparam int BEAT_W    = $clog2(BEAT_NUM)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_lrum_ready,
  input  logic                  i_lkp_val,
  input  logic [ADDR_WIDTH-1:0] i_lkp_addr,
  input  logic                  i_lkp_hit,
  input  logic                  i_lkp_evict_val,
  input  logic                  i_lkp_dirty,
  input  logic [TAG_W-1:0]      i_lkp_victim_tag,
  input  logic [WAY_NUM-1:0]    i_lkp_way_vect,
  output logic                  o_stall,
  output logic                  o_replay,
  output logic                  o_dat_rd_en,
  output logic [WAY_NUM-1:0]    o_dat_rd_way,
  output logic [IDX_WIDTH-1:0]  o_dat_rd_idx,
  output logic [BEAT_W-1:0]     o_dat_rd_beat,
  input  logic [BEAT_WIDTH-1:0] i_dat_rd_data,
  output logic                  o_mem_req_val,
  input  logic                  i_mem_req_ack,
  output logic                  o_mem_req_cmd,
  output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
  output logic [BEAT_WIDTH-1:0] o_mem_req_wdata,
  input  logic                  i_mem_rsp_val,
  input  logic [BEAT_WIDTH-1:0] i_mem_rsp_data,
  output logic                  o_fill_en,
  output logic [WAY_NUM-1:0]    o_fill_way,
  output logic [IDX_WIDTH-1:0]  o_fill_idx,
  output logic [BEAT_W-1:0]     o_fill_beat,
  output logic [BEAT_WIDTH-1:0] o_fill_data,
  output logic                  o_fill_tag_en,
  output logic [TAG_W-1:0]      o_fill_tag
);

  localparam int BOFF_W = OFF_W - BEAT_W;

  logic [2:0]                r_state, w_state_nxt;
  logic [BEAT_W-1:0]         r_beat_cnt, w_beat_nxt;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [WAY_NUM-1:0]        r_way;
  logic [TAG_W-1:0]          r_victim_tag;
  logic                      r_rd_pend;
  logic [BEAT_WIDTH-1:0]     r_wb_data;

  logic                      w_miss, w_last, w_req_val, w_fill;
  logic [IDX_WIDTH-1:0]      w_idx;
  logic [TAG_W-1:0]          w_tag;
  logic                      w_unused;

  assign w_idx     = r_addr[OFF_W +: IDX_WIDTH];
  assign w_tag     = r_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_unused  = ^r_addr[OFF_W-1:0];
  assign w_miss    = (r_state == S_IDLE) && i_lkp_val && !i_lkp_hit;
  assign w_last    = &r_beat_cnt;
  // Reset squashes memory and fill strobes immediately so an aborted miss never leaks a write.
  assign w_req_val = !i_rst && ((r_state == S_WB_REQ) || (r_state == S_RD_REQ));
  assign w_fill    = !i_rst && (r_state == S_FILL) && i_mem_rsp_val;

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    case (r_state)
      S_RST_WAIT: if (i_lrum_ready) w_state_nxt = S_IDLE;
      S_IDLE:     if (w_miss) w_state_nxt = (i_lkp_evict_val && i_lkp_dirty) ? S_WB_RD : S_RD_REQ;
      S_WB_RD:    w_state_nxt = S_WB_REQ;
      S_WB_REQ: begin
        if (i_mem_req_ack) begin
          w_beat_nxt  = w_last ? '0 : r_beat_cnt + BEAT_W'(1);
          w_state_nxt = w_last ? S_RD_REQ : S_WB_RD;
        end
      end
      S_RD_REQ:   if (i_mem_req_ack) w_state_nxt = S_FILL;
      S_FILL: begin
        if (i_mem_rsp_val) begin
          w_beat_nxt = r_beat_cnt + BEAT_W'(1);
          if (w_last) w_state_nxt = S_REPLAY;
        end
      end
      S_REPLAY:   w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_RST_WAIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_RST_WAIT;
      r_beat_cnt   <= '0;
      r_addr       <= '0;
      r_way        <= '0;
      r_victim_tag <= '0;
      r_rd_pend    <= 1'b0;
      r_wb_data    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_rd_pend  <= (r_state == S_WB_RD);
      if (r_rd_pend) r_wb_data <= i_dat_rd_data;
      if (w_miss) begin
        r_addr       <= i_lkp_addr;
        r_way        <= i_lkp_way_vect;
        r_victim_tag <= i_lkp_victim_tag;
      end
    end
  end

  assign o_stall       = (r_state != S_IDLE) || w_miss;
  assign o_replay      = (r_state == S_REPLAY);
  assign o_dat_rd_en   = (r_state == S_WB_RD);
  assign o_dat_rd_way  = o_dat_rd_en ? r_way : '0;
  assign o_dat_rd_idx  = o_dat_rd_en ? w_idx : '0;
  assign o_dat_rd_beat = o_dat_rd_en ? r_beat_cnt : '0;

  assign o_mem_req_val = w_req_val;
  assign o_mem_req_cmd = w_req_val && (r_state == S_WB_REQ) ? MEM_CMD_WR : MEM_CMD_RD;

  // First request cycle after the array read sees the data straight off the array; later cycles use the copy.
  always_comb begin
    o_mem_req_addr  = '0;
    o_mem_req_wdata = '0;
    if (w_req_val && (r_state == S_WB_REQ)) begin
      o_mem_req_addr  = {r_victim_tag, w_idx, r_beat_cnt, {BOFF_W{1'b0}}};
      o_mem_req_wdata = r_rd_pend ? i_dat_rd_data : r_wb_data;
    end else if (w_req_val) begin
      o_mem_req_addr  = {w_tag, w_idx, {OFF_W{1'b0}}};
    end
  end

  assign o_fill_en     = w_fill;
  assign o_fill_way    = w_fill ? r_way : '0;
  assign o_fill_idx    = w_fill ? w_idx : '0;
  assign o_fill_beat   = w_fill ? r_beat_cnt : '0;
  assign o_fill_data   = w_fill ? i_mem_rsp_data : '0;
  assign o_fill_tag_en = w_fill && w_last;
  assign o_fill_tag    = o_fill_tag_en ? w_tag : '0;

  a_miss_way_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    w_miss |-> $onehot(i_lkp_way_vect));

endmodule

// File: tb/tb_l1_miss_ctrl.sv
// Directed bench for l1_miss_ctrl: table of per-cycle vectors plus hand-written write-back and reset sequences.
module tb_l1_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst, lrum_ready, lkp_val, lkp_hit, lkp_evict_val, lkp_dirty;
  logic [31:0] lkp_addr;
  logic [20:0] lkp_victim_tag;
  logic [3:0]  lkp_way_vect;
  logic        stall, replay, dat_rd_en;
  logic [3:0]  dat_rd_way;
  logic [6:0]  dat_rd_idx;
  logic [1:0]  dat_rd_beat;
  logic [31:0] dat_rd_data;
  logic        mem_req_val, mem_req_ack, mem_req_cmd;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_val;
  logic [31:0] mem_rsp_data;
  logic        fill_en, fill_tag_en;
  logic [3:0]  fill_way;
  logic [6:0]  fill_idx;
  logic [1:0]  fill_beat;
  logic [31:0] fill_data;
  logic [20:0] fill_tag;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  l1_miss_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_lrum_ready(lrum_ready),
    .i_lkp_val(lkp_val), .i_lkp_addr(lkp_addr), .i_lkp_hit(lkp_hit),
    .i_lkp_evict_val(lkp_evict_val), .i_lkp_dirty(lkp_dirty),
    .i_lkp_victim_tag(lkp_victim_tag), .i_lkp_way_vect(lkp_way_vect),
    .o_stall(stall), .o_replay(replay),
    .o_dat_rd_en(dat_rd_en), .o_dat_rd_way(dat_rd_way), .o_dat_rd_idx(dat_rd_idx),
    .o_dat_rd_beat(dat_rd_beat), .i_dat_rd_data(dat_rd_data),
    .o_mem_req_val(mem_req_val), .i_mem_req_ack(mem_req_ack), .o_mem_req_cmd(mem_req_cmd),
    .o_mem_req_addr(mem_req_addr), .o_mem_req_wdata(mem_req_wdata),
    .i_mem_rsp_val(mem_rsp_val), .i_mem_rsp_data(mem_rsp_data),
    .o_fill_en(fill_en), .o_fill_way(fill_way), .o_fill_idx(fill_idx), .o_fill_beat(fill_beat),
    .o_fill_data(fill_data), .o_fill_tag_en(fill_tag_en), .o_fill_tag(fill_tag)
  );

  // Data-array model: beat-tagged data one cycle after a read, junk otherwise.
  always @(posedge clk) dat_rd_data <= dat_rd_en ? (32'hD000_0000 | {30'd0, dat_rd_beat}) : 32'hDEAD_BEEF;

  typedef struct {
    logic        lv;
    logic        hit;
    logic [31:0] addr;
    logic [3:0]  way;
    logic        ack;
    logic        rv;
    logic [31:0] rdata;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [127:0] mkexp(input logic st, input logic rp, input logic v, input logic c,
                                         input logic [31:0] a, input logic fe, input logic [1:0] fb,
                                         input logic [3:0] fw, input logic te, input logic [20:0] tg,
                                         input logic [31:0] fd);
    return {31'd0, st, rp, v, c, a, fe, fb, fw, te, tg, fd};
  endfunction

  function automatic logic [127:0] e_idle();  return mkexp(0,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [127:0] e_stall(); return mkexp(1,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [127:0] e_rep();   return mkexp(1,1,0,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [127:0] e_rd(input logic [31:0] a); return mkexp(1,0,1,0,a,0,0,0,0,0,0); endfunction
  function automatic logic [127:0] e_fill(input logic [1:0] b, input logic [3:0] w, input logic last,
                                          input logic [20:0] tg, input logic [31:0] d);
    return mkexp(1,0,0,0,0,1,b,w,last,last ? tg : 21'd0,d);
  endfunction

  function automatic logic [127:0] obs();
    return {31'd0, stall, replay, mem_req_val, mem_req_cmd, mem_req_addr, fill_en, fill_beat,
            fill_way, fill_tag_en, fill_tag, fill_data};
  endfunction

  function automatic logic [79:0] obs_wb();
    return {dat_rd_en, dat_rd_way, dat_rd_idx, dat_rd_beat, mem_req_val, mem_req_cmd, mem_req_addr, mem_req_wdata};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic lv, input logic hit, input logic [31:0] a, input logic [3:0] w,
                     input logic ack, input logic rv, input logic [31:0] rd, input logic [127:0] exp);
    vec_t v;
    v.lv = lv; v.hit = hit; v.addr = a; v.way = w; v.ack = ack; v.rv = rv; v.rdata = rd; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string name, input logic [127:0] exp);
    @(negedge clk);
    chk(name, obs(), exp);
    tick();
  endtask

  task automatic clear_lkp();
    lkp_val = 0; lkp_hit = 0; lkp_addr = 0; lkp_way_vect = 0;
    lkp_evict_val = 0; lkp_dirty = 0; lkp_victim_tag = 0;
  endtask

  initial begin
    int pat[9];
    int b;
    pat = '{1,0,0,1,0,1,0,0,1};

    // Hit, stray response and stray ack in IDLE: nothing happens.
    add(1,1,32'h0000_1040,4'b0001,0,0,0,e_idle());
    add(0,0,0,0,0,1,32'hBAD0_BAD0,e_idle());
    add(0,0,0,0,1,0,0,e_idle());
    // Clean miss, ack on the fourth request cycle, four back-to-back beats (tag 4, way 1).
    add(1,0,32'h0000_2080,4'b0010,0,0,0,e_stall());
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,0,0,e_rd(32'h0000_2080));
    add(0,0,0,0,1,0,0,e_rd(32'h0000_2080));
    for (int i = 0; i < 4; i++)
      add(0,0,0,0,0,1,32'hA000_0000 + i,e_fill(2'(i),4'b0010,i == 3,21'd4,32'hA000_0000 + i));
    add(0,0,0,0,0,0,0,e_rep());
    add(0,0,0,0,0,0,0,e_idle());
    // Gapped refill (tag 6, way 2), then a spurious beat once back in IDLE.
    add(1,0,32'h0000_3100,4'b0100,0,0,0,e_stall());
    add(0,0,0,0,1,0,0,e_rd(32'h0000_3100));
    b = 0;
    for (int i = 0; i < 9; i++) begin
      if (pat[i] == 1) begin
        add(0,0,0,0,0,1,32'hB000_0000 + b,e_fill(2'(b),4'b0100,b == 3,21'd6,32'hB000_0000 + b));
        b++;
      end else begin
        add(0,0,0,0,0,0,32'h5555_5555,e_stall());
      end
    end
    add(0,0,0,0,0,0,0,e_rep());
    add(0,0,0,0,0,1,32'hBAD1_BAD1,e_idle());

    rst = 1; lrum_ready = 0; mem_req_ack = 0; mem_rsp_val = 0; mem_rsp_data = 0;
    clear_lkp();
    repeat (3) tick();
    @(negedge clk);
    chk("reset_state", obs(), e_stall());
    chk("reset_wb_side", {48'd0, obs_wb()}, 128'd0);
    tick();

    // Lookups are ignored while waiting for the tag/LRU clean.
    rst = 0; lkp_val = 1; lkp_hit = 0; lkp_addr = 32'h0000_2080; lkp_way_vect = 4'b0001;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      chk($sformatf("rst_wait[%0d]", i), {125'd0, stall, mem_req_val, fill_en}, {125'd0, 3'b100});
      tick();
    end
    clear_lkp();
    lrum_ready = 1;
    step_chk("ready_cycle", e_stall());
    lrum_ready = 0;
    step_chk("idle_after_ready", e_idle());

    foreach (vecs[i]) begin
      lkp_val = vecs[i].lv; lkp_hit = vecs[i].hit; lkp_addr = vecs[i].addr; lkp_way_vect = vecs[i].way;
      mem_req_ack = vecs[i].ack; mem_rsp_val = vecs[i].rv; mem_rsp_data = vecs[i].rdata;
      step_chk($sformatf("vec[%0d]", i), vecs[i].exp);
    end
    clear_lkp(); mem_req_ack = 0; mem_rsp_val = 0;

    // Dirty evict: victim tag 0x68, idx 5 -> write-back to 0x0003_4050.. ; new line 0x0000_8050 (tag 0x10).
    lkp_val = 1; lkp_addr = 32'h0000_8050; lkp_way_vect = 4'b1000;
    lkp_evict_val = 1; lkp_dirty = 1; lkp_victim_tag = 21'h68;
    step_chk("wb_miss", e_stall());
    clear_lkp();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("wb_rd[%0d]", i), {48'd0, obs_wb()},
          {48'd0, 1'b1, 4'b1000, 7'd5, 2'(i), 1'b0, 1'b0, 32'd0, 32'd0});
      tick();
      for (int k = 0; k < 2; k++) begin
        mem_req_ack = (k == 1);
        @(negedge clk);
        chk($sformatf("wb_req[%0d.%0d]", i, k), {48'd0, obs_wb()},
            {48'd0, 1'b0, 4'd0, 7'd0, 2'd0, 1'b1, 1'b1, 32'h0003_4050 + 32'(4 * i), 32'hD000_0000 + i});
        tick();
      end
      mem_req_ack = 0;
    end
    mem_req_ack = 1;
    step_chk("wb_line_rd", e_rd(32'h0000_8050));
    mem_req_ack = 0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_val = 1; mem_rsp_data = 32'hC000_0000 + i;
      step_chk($sformatf("wb_fill[%0d]", i), e_fill(2'(i),4'b1000,i == 3,21'h10,32'hC000_0000 + i));
    end
    mem_rsp_val = 0;
    step_chk("wb_replay", e_rep());
    step_chk("wb_idle", e_idle());

    // Reset after the third refill beat aborts the miss.
    lkp_val = 1; lkp_addr = 32'h0000_2080; lkp_way_vect = 4'b0001;
    step_chk("abort_miss", e_stall());
    clear_lkp();
    mem_req_ack = 1;
    step_chk("abort_rd", e_rd(32'h0000_2080));
    mem_req_ack = 0;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_val = 1; mem_rsp_data = 32'hE000_0000 + i;
      step_chk($sformatf("abort_fill[%0d]", i), e_fill(2'(i),4'b0001,1'b0,21'd4,32'hE000_0000 + i));
    end
    mem_rsp_val = 0; rst = 1;
    tick();
    rst = 0; mem_rsp_val = 1; mem_rsp_data = 32'hE000_0003; mem_req_ack = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("after_rst[%0d]", i), obs(), e_stall());
      chk($sformatf("after_rst_wb[%0d]", i), {48'd0, obs_wb()}, 128'd0);
      tick();
    end
    mem_rsp_val = 0; mem_req_ack = 0; lrum_ready = 1;
    step_chk("rearm_ready", e_stall());
    lrum_ready = 0;
    step_chk("rearm_idle", e_idle());

    // Fresh miss must start refilling at beat 0.
    lkp_val = 1; lkp_addr = 32'h0000_2080; lkp_way_vect = 4'b0001;
    step_chk("post_miss", e_stall());
    clear_lkp();
    mem_req_ack = 1;
    step_chk("post_rd", e_rd(32'h0000_2080));
    mem_req_ack = 0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_val = 1; mem_rsp_data = 32'hF000_0000 + i;
      step_chk($sformatf("post_fill[%0d]", i), e_fill(2'(i),4'b0001,i == 3,21'd4,32'hF000_0000 + i));
    end
    mem_rsp_val = 0;
    step_chk("post_replay", e_rep());
    step_chk("post_idle", e_idle());

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
